sprite_reader: RTL

Read-side pipeline for the 20x20, 3-bit-per-pixel sprite RAM in the VGA datapath. Per pixel, it compares the raster coordinate (DrawX, DrawY) against a double-buffered sprite position and generates the RAM read address. It absorbs the RAM's one-cycle registered read latency and delivers an aligned colour index plus hit flag to the colour mapper. Position updates take effect only at frame boundaries, so sprites never tear mid-frame.

---
 rtl/sprite_pkg.sv | 32 +++
 rtl/sprite_addr_calc.sv | 48 ++++
 rtl/sprite_reader.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared definitions for the 20x20, 3-bit-per-pixel sprite RAM.
// Used by the sprite read pipeline, the sprite RAM and the colour mapper.
// Optional feature macro: SPRITE_MIRROR_EN (horizontal mirroring).
package sprite_pkg;

  localparam int unsigned SPR_W   = 20;
  localparam int unsigned SPR_H   = 20;
  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned PIX_W   = 3;
  localparam int unsigned COORD_W = 10;

  typedef logic [ADDR_W-1:0]  sprite_addr_t;
  typedef logic [PIX_W-1:0]   pixel_t;
  typedef logic [COORD_W-1:0] coord_t;

  // Colour index 0 lets the background show through.
  localparam pixel_t TRANSPARENT = '0;

  localparam logic [31:0] SPR_W_BITS = SPR_W;

  // row * SPR_W as a sum of shifted rows (for 20: row<<4 + row<<2),
  // avoiding a generic multiplier in the address path.
  function automatic sprite_addr_t row_base(input sprite_addr_t row);
    sprite_addr_t acc;
    acc = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      if (SPR_W_BITS[i]) acc = acc + (row << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/sprite_addr_calc.sv
// Combinational hit test and RAM address generation for one raster pixel.
// Optional feature macro: SPRITE_MIRROR_EN adds a horizontal mirror input.
module sprite_addr_calc
  import sprite_pkg::*;
(
  input  logic         pix_valid,
  input  coord_t       draw_x,
  input  coord_t       draw_y,
  input  coord_t       act_x,
  input  coord_t       act_y,
  input  logic         act_en,
`ifdef SPRITE_MIRROR_EN
  input  logic         mirror,
`endif
  output logic         in_box,
  output sprite_addr_t addr
);

  localparam coord_t       W_LIM   = coord_t'(SPR_W);
  localparam coord_t       H_LIM   = coord_t'(SPR_H);
  localparam sprite_addr_t COL_MAX = sprite_addr_t'(SPR_W - 1);

  // One extra bit makes the differences signed: the top bit set means the
  // raster is left of / above the sprite, so a sprite near x=1023 cannot
  // wrap around and hit on the left edge of the screen.
  logic [COORD_W:0] dx;
  logic [COORD_W:0] dy;
  logic             x_in;
  logic             y_in;
  sprite_addr_t     col;
  sprite_addr_t     row;

  // Offset into the sprite, box test, optional mirror, then row*W + column.
  always_comb begin
    dx     = {1'b0, draw_x} - {1'b0, act_x};
    dy     = {1'b0, draw_y} - {1'b0, act_y};
    x_in   = ~dx[COORD_W] && (dx[COORD_W-1:0] < W_LIM);
    y_in   = ~dy[COORD_W] && (dy[COORD_W-1:0] < H_LIM);
    in_box = pix_valid & act_en & x_in & y_in;
    row    = sprite_addr_t'(dy[COORD_W-1:0]);
    col    = sprite_addr_t'(dx[COORD_W-1:0]);
`ifdef SPRITE_MIRROR_EN
    if (mirror) col = COL_MAX - col;
`endif
    addr   = in_box ? (row_base(row) + col) : '0;
  end

endmodule

// File: rtl/sprite_reader.sv
// Sprite read pipeline: double-buffered position, address generation,
// RAM latency alignment and final hit/colour output.
// Optional feature macro: SPRITE_MIRROR_EN adds the mirror_x input.
//
// Stream semantics: valid-only, no backpressure. pix_valid marks a real
// pixel in the cycle it is presented; out_valid marks the matching result
// exactly three cycles later. Bubbles travel through as out_valid=0.
module sprite_reader
  import sprite_pkg::*;
(
  input  logic         Clk,
  input  logic         Reset,
  input  logic         frame_start,
  input  logic         pos_load,
  input  coord_t       pos_x,
  input  coord_t       pos_y,
`ifdef SPRITE_MIRROR_EN
  input  logic         mirror_x,
`endif
  input  logic         pix_valid,
  input  coord_t       DrawX,
  input  coord_t       DrawY,
  output sprite_addr_t read_address,
  input  pixel_t       mem_data,
  output logic         out_valid,
  output logic         out_hit,
  output pixel_t       out_color
);

  coord_t       pend_x;
  coord_t       pend_y;
  logic         pend_en;
  coord_t       act_x;
  coord_t       act_y;
  logic         act_en;
`ifdef SPRITE_MIRROR_EN
  logic         pend_mir;
  logic         act_mir;
`endif

  logic         in_box;
  sprite_addr_t calc_addr;
  logic         v1;
  logic         b1;
  logic         v2;
  logic         b2;
  logic         hit_now;

  sprite_addr_calc u_calc (
    .pix_valid (pix_valid),
    .draw_x    (DrawX),
    .draw_y    (DrawY),
    .act_x     (act_x),
    .act_y     (act_y),
    .act_en    (act_en),
`ifdef SPRITE_MIRROR_EN
    .mirror    (act_mir),
`endif
    .in_box    (in_box),
    .addr      (calc_addr)
  );

  // Position double buffer: loads land in pending, frame_start publishes
  // them; a load coinciding with frame_start bypasses straight to active.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pend_x  <= '0;
      pend_y  <= '0;
      pend_en <= 1'b0;
      act_x   <= '0;
      act_y   <= '0;
      act_en  <= 1'b0;
    end else begin
      if (pos_load) begin
        pend_x  <= pos_x;
        pend_y  <= pos_y;
        pend_en <= 1'b1;
      end
      if (frame_start) begin
        act_x  <= pos_load ? pos_x : pend_x;
        act_y  <= pos_load ? pos_y : pend_y;
        act_en <= pos_load | pend_en;
      end
    end
  end

`ifdef SPRITE_MIRROR_EN
  // Mirror flag follows the same pending/active path as the position.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pend_mir <= 1'b0;
      act_mir  <= 1'b0;
    end else begin
      if (pos_load)    pend_mir <= mirror_x;
      if (frame_start) act_mir  <= pos_load ? mirror_x : pend_mir;
    end
  end
`endif

  // Stage 1: register the RAM address plus valid/in-box flags.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      read_address <= '0;
      v1           <= 1'b0;
      b1           <= 1'b0;
    end else begin
      read_address <= calc_addr;
      v1           <= pix_valid;
      b1           <= in_box;
    end
  end

  // Stage 2: flags wait while the RAM performs its registered read.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      v2 <= 1'b0;
      b2 <= 1'b0;
    end else begin
      v2 <= v1;
      b2 <= b1;
    end
  end

  // A pixel is drawn only inside the box and where the colour is opaque.
  always_comb begin
    hit_now = b2 && (mem_data != TRANSPARENT);
  end

  // Stage 3: aligned result for the colour mapper.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid <= 1'b0;
      out_hit   <= 1'b0;
      out_color <= '0;
    end else begin
      out_valid <= v2;
      out_hit   <= hit_now;
      out_color <= hit_now ? mem_data : '0;
    end
  end

endmodule
